// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end.
// Issues one word address per cycle to a synchronous code memory, matches the
// returned word with its address one cycle later, and uses a one-entry skid
// buffer so a downstream stall never loses or duplicates an instruction.
// An out-of-range or misaligned fetch address parks the unit in FAULT until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned SIZE     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_inst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        fetch_fault
);

    localparam logic [31:0] SIZE_LIM = 32'(SIZE);

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t      state_q, state_d;
    logic        fault_q, fault_d;
    logic [31:0] pc_q, pc_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        run;
    logic        redirect;
    logic        pc_legal;
    logic        issue;
    logic        have_inst;
    logic [31:0] sel_inst;
    logic [31:0] sel_pc;

    // Issue decision and next-state computation for all fetch state.
    always_comb begin
        run      = (state_q == RUN);
        // Redirects are only honoured while running; FAULT ignores them.
        redirect = run && branch_taken;
        pc_legal = (pc_q < SIZE_LIM) && (pc_q[1:0] == 2'b00);
        issue    = run && !stall && !branch_taken && pc_legal;

        state_d = state_q;
        fault_d = fault_q;
        if (run && !stall && !branch_taken && !pc_legal) begin
            state_d = FAULT;
            fault_d = 1'b1;
        end

        pc_d = pc_q;
        if (redirect) begin
            pc_d = branch_target;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end

        // A cycle without issue discards whatever the memory returns next.
        f_valid_d = issue;
        f_pc_d    = issue ? pc_q : f_pc_q;

        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        if (redirect) begin
            skid_valid_d = 1'b0;
        end else if (skid_valid_q && !stall) begin
            skid_valid_d = 1'b0;
        end else if (stall && f_valid_q && !skid_valid_q) begin
            // Memory word is only on mem_inst this cycle; park it while stalled.
            skid_valid_d = 1'b1;
            skid_inst_d  = mem_inst;
            skid_pc_d    = f_pc_q;
        end
    end

    // Output selection: the skid entry is always older than the in-flight fetch.
    always_comb begin
        if (skid_valid_q) begin
            have_inst = 1'b1;
            sel_inst  = skid_inst_q;
            sel_pc    = skid_pc_q;
        end else begin
            have_inst = f_valid_q;
            sel_inst  = mem_inst;
            sel_pc    = f_pc_q;
        end
        inst_valid  = have_inst && !redirect;
        inst_out    = inst_valid ? sel_inst : 32'h0;
        pc_out      = sel_pc;
        mem_addr    = pc_q;
        fetch_fault = fault_q;
    end

    // Control state and FSM, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            fault_q      <= 1'b0;
            pc_q         <= RESET_PC;
            f_valid_q    <= 1'b0;
            f_pc_q       <= 32'h0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            pc_q         <= pc_d;
            f_valid_q    <= f_valid_d;
            f_pc_q       <= f_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Skid payload; only meaningful while skid_valid_q is set, so no reset.
    always_ff @(posedge clk) begin
        skid_inst_q <= skid_inst_d;
        skid_pc_q   <= skid_pc_d;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter SIZE, default 1024: code memory size in bytes; legal fetch addresses are 0..SIZE-4.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-005 mem_addr  out  32  byte address presented to code memory; memory returns the word one cycle later.
REQ-006 mem_inst  in  32  instruction word for the mem_addr sampled at the previous posedge.
REQ-007 stall  in  1  downstream not accepting this cycle.
REQ-008 branch_taken  in  1  redirect request, valid for one cycle.
REQ-009 branch_target  in  32  redirect byte address, qualified by branch_taken.
REQ-010 inst_valid  out  1  inst_out/pc_out hold a valid fetched instruction.
REQ-011 inst_out  out  32  fetched instruction word.
REQ-012 pc_out  out  32  byte address of inst_out.
REQ-013 fetch_fault  out  1  sticky out-of-bounds or misaligned fetch indication.

Function
REQ-014 State: pc_q (next issue address), f_valid/f_pc (fetch issued last cycle), one-entry skid buffer (skid_valid, skid_inst, skid_pc), FSM {RUN, FAULT}.
REQ-015 mem_addr SHALL equal pc_q combinationally.
REQ-016 issue = RUN and !stall and !branch_taken and pc_q legal; on issue: f_pc<=pc_q, f_valid<=1, pc_q<=pc_q+4 (32-bit wrap, no saturation).
REQ-017 No issue in a cycle: f_valid<=0, pc_q holds (the memory read that cycle is discarded).
REQ-018 pc_q legal = (pc_q < SIZE) and (pc_q[1:0] == 2'b00); if RUN, !stall, !branch_taken and pc_q illegal, FSM<=FAULT, no issue.
REQ-019 FAULT: no issue, fetch_fault=1, pc_q frozen (mem_addr shows faulting address); exit only via reset; branch_taken ignored in FAULT, though any skid/f instruction already held still drains as normal.
REQ-020 Output select: if skid_valid, present skid_inst/skid_pc; else present mem_inst/f_pc with f_valid.
REQ-021 inst_valid = (skid_valid or f_valid) and !branch_taken; when inst_valid=0, inst_out SHALL be 32'h0 and pc_out SHALL be the selected pc.
REQ-022 Transfer occurs when inst_valid=1 and stall=0; each fetched word SHALL transfer exactly once, in address order, unless squashed.
REQ-023 Capture: stall=1, f_valid=1, skid_valid=0, branch_taken=0 -> skid<=(mem_inst, f_pc), skid_valid<=1.
REQ-024 skid_valid=1 and stall=0 -> skid_valid<=0 in the same edge as the new issue; f_valid is always 0 while skid_valid=1.
REQ-025 branch_taken=1 (in RUN): pc_q<=branch_target, f_valid<=0, skid_valid<=0; takes priority over stall and capture.
REQ-026 Latency: issue at cycle t -> inst_valid at t+1; redirect at cycle t -> first target instruction valid at t+2 if stall=0 at t+1.
REQ-027 Steady state with stall=0: one instruction per cycle, no bubbles.

Reset
REQ-028 Asserted reset: pc_q=RESET_PC, f_valid=0, f_pc=0, skid_valid=0, FSM=RUN; hence mem_addr=RESET_PC, inst_valid=0, inst_out=0, pc_out=0, fetch_fault=0.
REQ-029 Reset mid-operation SHALL discard in-flight and skid instructions; first issue occurs at the first posedge after deassertion with stall=0.

Verification
REQ-030 Reset release, stall=0, memory word[i]=i: pc_out 0,4,8,... on consecutive cycles, inst_out 0,1,2,..., first inst_valid one cycle after the first issue edge.
REQ-031 Stall asserted 3 cycles while pc_out=8: inst_out holds word 2 with inst_valid=1 throughout; after release, sequence continues 3,4 with no loss and no duplicate.
REQ-032 branch_taken with target 0x40 while pc_out=0x10: inst_valid=0 in branch cycle, 0x14 never delivered, pc_out=0x40 two cycles later.
REQ-033 Branch concurrent with stall and full skid: skid squashed, stall held 2 more cycles -> no valid output; after release, 0x40 delivered.
REQ-034 SIZE=16, run from 0: words 0..3 delivered, then fetch_fault=1, mem_addr=0x10, inst_valid=0 thereafter; branch to 0x0 ignored; branch_target=0x2 after reset -> fault at 0x2, nothing delivered.
REQ-035 Reset asserted asynchronously mid-stall with skid full: outputs reach REQ-028 values before the next posedge; restart from RESET_PC.
